spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- 32-bit SPI mode-0 initiator: the other end of the board's SPI slave command link.
- Lets an on-FPGA controller or a test harness issue command frames and capture the returned word:
  - drive-motor frames;
  - send-data address selects.
- Full-duplex: one frame shifts out tx_data MSB-first while capturing MISO into rx_data.
- Chip-select, setup, hold and inter-frame gap timing are generated here.

Parameters:
- DATA_WIDTH, 32: bits per frame; must match the slave frame width.
- CLK_DIV, 8: GCLK cycles per SPI_CLK half-period; legal range is 2 or more.
- CS_SETUP, 1: SPI half-periods from CS falling to the first SPI_CLK rising edge.
- CS_HOLD, 1: SPI half-periods from the last SPI_CLK falling edge to CS rising.
- GAP, 2: SPI half-periods with CS high before the next frame may start.

Ports:
- GCLK, input, 1: system clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: frame request; sampled only while busy=0.
- tx_data, input, DATA_WIDTH: word to send; captured in the cycle start is accepted.
- busy, output, 1: high from the cycle after start is accepted through the end of GAP.
- done, output, 1: one-GCLK pulse when the frame is complete and rx_data is valid.
- rx_data, output, DATA_WIDTH: last received word; holds until the next done.
- SPI_CLK, output, 1: serial clock; idles low (CPOL=0).
- SPI_MOSI, output, 1: serial data out.
- SPI_MISO, input, 1: serial data in from the slave.
- CS, output, 1: chip select, active-low; idles high.

Behaviour:
- Reset (reset=0, asynchronous), all immediate, including mid-frame:
  - state=IDLE; busy=0; done=0; rx_data=0;
  - SPI_CLK=0; SPI_MOSI=0; CS=1; divider counter=0; bit counter=0.
- On release, the first action is no earlier than the next GCLK edge.
- Divider: a counter 0..CLK_DIV-1 runs only outside IDLE. It emits tick when it reaches CLK_DIV-1, then wraps to 0. All SPI timing is in ticks.
- FSM states are IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - When start=1, latch tx_data into the shift register and go to SETUP.
  - In the next cycle: CS=0, busy=1, SPI_MOSI=tx_data[DATA_WIDTH-1].
- SETUP: after CS_SETUP ticks, go to SHIFT with SPI_CLK still low.
- SHIFT (mode 0):
  - Each tick toggles SPI_CLK.
  - On the tick that raises SPI_CLK, sample SPI_MISO into the receive shift register LSB, shifting left.
  - On the tick that lowers SPI_CLK, increment the bit counter. If fewer than DATA_WIDTH bits are done, shift the transmit register left so SPI_MOSI shows the next bit.
  - After the DATA_WIDTH-th falling edge, go to HOLD with SPI_MOSI held at the last bit.
  - Exactly DATA_WIDTH rising edges per frame, never more.
- HOLD: after CS_HOLD ticks:
  - CS=1, SPI_MOSI=0;
  - rx_data loads the receive register;
  - done=1 for exactly one cycle in that same cycle;
  - go to GAP.
- GAP: after GAP ticks, go to IDLE with busy=0.
  - A start asserted in that same cycle is not accepted; acceptance is earliest one cycle later.
- start while busy=1 is ignored, not queued. tx_data changes during a frame have no effect.
- Frame length in GCLK cycles, start-accept to busy falling = 1 + CLK_DIV*(CS_SETUP + 2*DATA_WIDTH + CS_HOLD + GAP).
  - Defaults: 1 + 8*(1+64+1+2) = 545.
- Protocol note: the slave returns the word selected by the previously loaded address. Callers issue a send-data frame, then any second frame, and read rx_data from the second frame's done.
- SPI_MISO is used unsynchronised. It is sampled CLK_DIV cycles after the slave's falling-edge update, which requires CLK_DIV of 2 or more.

Decomposition:
- spi_pkg holds:
  - SPI_DATA_WIDTH=32;
  - CMD_DRIVE_MOTOR=8'h00 and CMD_SEND_DATA=8'h01;
  - ADDR_DEBUG=8'd0, ADDR_ENCODER=8'd1, ADDR_PATTERN=8'd2;
  - the spi_master_state_t enum.
- One sub-module, spi_tick_gen: a parameterised divider with run input, tick output and async active-low reset. It is reusable for PWM and LED timing.

Test Plan:
- Loopback (MOSI tied to MISO), start with tx_data=32'hA5C3_0F01 → exactly 32 SPI_CLK rising edges; done once; rx_data=32'hA5C3_0F01; busy high for 545 cycles.
- Slave model returning 32'hFFFF0000 for address 2: frame 32'h0100_0002, then frame 32'h0100_0002 → second rx_data=32'hFFFF0000.
- Motor frame 32'h0000_1BE8 (motor 3, period 1000) → MOSI bit sequence matches MSB-first; CS low throughout all 32 bits; SPI_CLK low whenever CS rises or falls.
- start pulsed at bit 10 and again on the GAP→IDLE cycle → neither accepted; the following start one cycle later is accepted.
- reset=0 asserted mid-SHIFT at bit 17 → same cycle: CS=1, SPI_CLK=0, busy=0; rx_data=0; no done pulse; next frame after release is correct.
- CLK_DIV=2, loopback 32'h8000_0001 → rx_data=32'h8000_0001; SPI_CLK period exactly 4 GCLK cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command-link initiator.
// Holds the frame width, command/address codes understood by the board's
// SPI slave, and the initiator FSM state encoding.
package spi_pkg;

    localparam int unsigned SPI_DATA_WIDTH = 32;

    // Command byte (frame bits [31:24])
    localparam logic [7:0] CMD_DRIVE_MOTOR = 8'h00;
    localparam logic [7:0] CMD_SEND_DATA   = 8'h01;

    // Readback address selects for CMD_SEND_DATA (frame bits [7:0])
    localparam logic [7:0] ADDR_DEBUG   = 8'd0;
    localparam logic [7:0] ADDR_ENCODER = 8'd1;
    localparam logic [7:0] ADDR_PATTERN = 8'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_master_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Free-running divider that emits a one-cycle tick every DIV clocks while run=1.
// Ports: clk, rst_n (async active-low), run (count enable; clears when low),
//        tick (registered; high for the cycle after the count reaches DIV-1).
module spi_tick_gen #(
    parameter int unsigned DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Count 0..DIV-1 and wrap; hold at zero whenever stopped.
    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (run) begin
            tick_d = (cnt_q == CNT_W'(DIV - 1));
            cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) SPI initiator for the board command link.
// One start shifts tx_data out MSB-first on SPI_MOSI while capturing SPI_MISO
// into rx_data; CS setup, hold and inter-frame gap are timed in divider ticks.
// Ports: GCLK, reset (async active-low), start/tx_data (request, sampled while
//        idle), busy/done/rx_data (status and result), SPI_CLK/SPI_MOSI/CS
//        (serial outputs), SPI_MISO (serial input, used unsynchronised).
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int unsigned CLK_DIV    = 8,
    parameter int unsigned CS_SETUP   = 1,
    parameter int unsigned CS_HOLD    = 1,
    parameter int unsigned GAP        = 2
) (
    input  logic                  GCLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  SPI_CLK,
    output logic                  SPI_MOSI,
    input  logic                  SPI_MISO,
    output logic                  CS
);

    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int unsigned WAIT_W = 8;

    spi_master_state_t     state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_q, cs_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  run_c;
    logic                  tick_c;

    assign run_c = (state_q != ST_IDLE);

    spi_tick_gen #(
        .DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (GCLK),
        .rst_n (reset),
        .run   (run_c),
        .tick  (tick_c)
    );

    // Frame sequencing; all serial outputs come straight from flops.
    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        wait_d    = wait_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_sh_d   = tx_data;
                    bit_cnt_d = '0;
                    wait_d    = '0;
                    sclk_d    = 1'b0;
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick_c) begin
                    if (wait_q == WAIT_W'(CS_SETUP - 1)) begin
                        wait_d  = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            ST_SHIFT: begin
                if (tick_c) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: capture MISO into the LSB.
                        rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], SPI_MISO};
                    end else begin
                        // Falling edge: bit complete; present the next one
                        // unless this was the last, which stays on MOSI.
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                            state_d = ST_HOLD;
                        end else begin
                            tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick_c) begin
                    if (wait_q == WAIT_W'(CS_HOLD - 1)) begin
                        wait_d    = '0;
                        cs_d      = 1'b1;
                        tx_sh_d   = '0;
                        rx_data_d = rx_sh_q;
                        done_d    = 1'b1;
                        state_d   = ST_GAP;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick_c) begin
                    if (wait_q == WAIT_W'(GAP - 1)) begin
                        wait_d  = '0;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge GCLK or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            wait_q    <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            wait_q    <= wait_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign SPI_CLK  = sclk_q;
    assign SPI_MOSI = tx_sh_q[DATA_WIDTH-1];
    assign CS       = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, a board-slave model, start
// filtering, mid-frame reset, and a CLK_DIV=2 instance.
module tb_spi_master;
    import spi_pkg::*;

    logic        GCLK = 1'b0;
    logic        reset;
    logic        start, start2;
    logic [31:0] tx_data, tx_data2;
    logic        busy, done, sclk, mosi, miso, cs;
    logic [31:0] rx_data;
    logic        busy2, done2, sclk2, mosi2, cs2;
    logic [31:0] rx_data2;
    logic        loop_sel;
    logic        slv_miso;

    int nvec = 0;
    int nmis = 0;

    always #5 GCLK = ~GCLK;

    assign miso = loop_sel ? mosi : slv_miso;

    spi_master dut (
        .GCLK(GCLK), .reset(reset), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .SPI_CLK(sclk), .SPI_MOSI(mosi), .SPI_MISO(miso), .CS(cs)
    );

    spi_master #(.CLK_DIV(2)) dut2 (
        .GCLK(GCLK), .reset(reset), .start(start2), .tx_data(tx_data2),
        .busy(busy2), .done(done2), .rx_data(rx_data2),
        .SPI_CLK(sclk2), .SPI_MOSI(mosi2), .SPI_MISO(mosi2), .CS(cs2)
    );

    // Monitors and slave model, sampled mid-cycle.
    int          rises = 0, dones = 0, busy_cyc = 0, cs_viol = 0, cs_edge_viol = 0;
    int          rises2 = 0, busy2_cyc = 0, per_bad = 0, cyc = 0, prev_rise = 0;
    logic        have_prev = 1'b0;
    logic        sclk_p = 1'b0, cs_p = 1'b1, sclk2_p = 1'b0;
    logic [31:0] mosi_cap = '0;
    logic [31:0] slv_in = '0, slv_out = '0;
    logic [7:0]  slv_addr = ADDR_DEBUG;

    function automatic logic [31:0] slv_resp(input logic [7:0] a);
        case (a)
            ADDR_DEBUG:   return 32'h1234_5678;
            ADDR_ENCODER: return 32'h0000_03E8;
            ADDR_PATTERN: return 32'hFFFF_0000;
            default:      return 32'h0000_0000;
        endcase
    endfunction

    assign slv_miso = slv_out[31];

    always @(negedge GCLK) begin
        cyc     <= cyc + 1;
        sclk_p  <= sclk;
        cs_p    <= cs;
        sclk2_p <= sclk2;
        if (busy)  busy_cyc  <= busy_cyc + 1;
        if (busy2) busy2_cyc <= busy2_cyc + 1;
        if (done)  dones     <= dones + 1;
        if (sclk && !sclk_p) begin
            rises    <= rises + 1;
            mosi_cap <= {mosi_cap[30:0], mosi};
            if (cs) cs_viol <= cs_viol + 1;
            if (!cs) slv_in <= {slv_in[30:0], mosi};
        end
        if (!sclk && sclk_p && !cs) slv_out <= {slv_out[30:0], 1'b0};
        if (cs != cs_p && (sclk || sclk_p)) cs_edge_viol <= cs_edge_viol + 1;
        if (!cs && cs_p) begin
            slv_in  <= '0;
            slv_out <= slv_resp(slv_addr);
        end
        if (cs && !cs_p && slv_in[31:24] == CMD_SEND_DATA) slv_addr <= slv_in[7:0];
        if (sclk2 && !sclk2_p) begin
            rises2    <= rises2 + 1;
            prev_rise <= cyc;
            have_prev <= 1'b1;
            if (have_prev && (cyc - prev_rise) != 4) per_bad <= per_bad + 1;
        end else if (cs2) begin
            have_prev <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(output logic ok);
        int n = 0;
        while (busy && n < 3000) begin @(posedge GCLK); #1; n++; end
        ok = !busy;
    endtask

    task automatic wait_done(output logic ok);
        int n = 0;
        while (!done && n < 3000) begin @(posedge GCLK); #1; n++; end
        ok = done;
    endtask

    task automatic do_frame(input logic [31:0] w, output logic ok);
        logic ok1, ok2, ok3;
        wait_idle(ok1);
        tx_data = w;
        start   = 1'b1;
        @(posedge GCLK); #1;
        start = 1'b0;
        wait_done(ok2);
        wait_idle(ok3);
        ok = ok1 && ok2 && ok3;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0, d0, b0, n;
        logic        ok, pulsed;

        reset = 1'b0; start = 1'b0; start2 = 1'b0;
        tx_data = '0; tx_data2 = '0; loop_sel = 1'b1;
        repeat (3) @(posedge GCLK);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_cs",   32'(cs),   32'd1);
        check_eq("rst_sclk", 32'(sclk), 32'd0);
        check_eq("rst_mosi", 32'(mosi), 32'd0);
        check_eq("rst_rx",   rx_data,   32'd0);
        reset = 1'b1;
        repeat (2) @(posedge GCLK);
        #1;

        // Loopback
        r0 = rises; d0 = dones; b0 = busy_cyc;
        do_frame(32'hA5C3_0F01, ok);
        check_eq("lb_timeout", 32'(ok), 32'd1);
        check_eq("lb_rises", 32'(rises - r0), 32'd32);
        check_eq("lb_dones", 32'(dones - d0), 32'd1);
        check_eq("lb_rx", rx_data, 32'hA5C3_0F01);
        check_eq("lb_busy_cycles", 32'(busy_cyc - b0), 32'd545);

        // Slave readback: first frame returns the previous (debug) word
        loop_sel = 1'b0;
        do_frame({CMD_SEND_DATA, 16'h0000, ADDR_PATTERN}, ok);
        check_eq("rd1_timeout", 32'(ok), 32'd1);
        check_eq("rd1_rx", rx_data, 32'h1234_5678);
        do_frame({CMD_SEND_DATA, 16'h0000, ADDR_PATTERN}, ok);
        check_eq("rd2_timeout", 32'(ok), 32'd1);
        check_eq("rd2_rx", rx_data, 32'hFFFF_0000);

        // Motor frame: MOSI order and CS/SPI_CLK relationship
        r0 = rises; n = cs_viol; b0 = cs_edge_viol;
        do_frame(32'h0000_1BE8, ok);
        check_eq("mot_timeout", 32'(ok), 32'd1);
        check_eq("mot_mosi", mosi_cap, 32'h0000_1BE8);
        check_eq("mot_rises", 32'(rises - r0), 32'd32);
        check_eq("mot_cs_low", 32'(cs_viol - n), 32'd0);
        check_eq("mot_cs_edge_sclk", 32'(cs_edge_viol - b0), 32'd0);
        check_eq("mot_rx", rx_data, 32'hFFFF_0000);

        // Starts while busy and on the GAP->IDLE cycle are ignored
        loop_sel = 1'b1;
        tx_data = 32'hCAFE_0001;
        start   = 1'b1;
        @(posedge GCLK); #1;
        start = 1'b0;
        r0 = rises; d0 = dones; pulsed = 1'b0;
        for (int i = 1; i <= 544; i++) begin
            @(posedge GCLK); #1;
            start = 1'b0;
            if (!pulsed && (rises - r0) >= 10) begin
                start   = 1'b1;
                tx_data = 32'h5555_5555;
                pulsed  = 1'b1;
            end
        end
        start = 1'b1;
        @(posedge GCLK); #1;
        check_eq("ign_pulsed", 32'(pulsed), 32'd1);
        check_eq("ign_gap_busy", 32'(busy), 32'd0);
        check_eq("ign_rises", 32'(rises - r0), 32'd32);
        check_eq("ign_dones", 32'(dones - d0), 32'd1);
        check_eq("ign_rx", rx_data, 32'hCAFE_0001);
        @(posedge GCLK); #1;
        start = 1'b0;
        check_eq("late_accept_busy", 32'(busy), 32'd1);
        wait_done(ok);
        check_eq("late_timeout", 32'(ok), 32'd1);
        check_eq("late_rx", rx_data, 32'h5555_5555);
        wait_idle(ok);

        // Reset mid-SHIFT
        tx_data = 32'h3C3C_3C3C;
        start   = 1'b1;
        @(posedge GCLK); #1;
        start = 1'b0;
        r0 = rises; n = 0;
        while ((rises - r0) < 17 && n < 3000) begin @(posedge GCLK); #1; n++; end
        check_eq("mid_reached_bit17", 32'(rises - r0), 32'd17);
        d0 = dones;
        reset = 1'b0;
        #1;
        check_eq("mid_cs",   32'(cs),   32'd1);
        check_eq("mid_sclk", 32'(sclk), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_rx",   rx_data,   32'd0);
        repeat (3) @(posedge GCLK);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge GCLK);
        #1;
        check_eq("mid_no_done", 32'(dones - d0), 32'd0);
        r0 = rises;
        do_frame(32'h0F0F_A5A5, ok);
        check_eq("post_timeout", 32'(ok), 32'd1);
        check_eq("post_rx", rx_data, 32'h0F0F_A5A5);
        check_eq("post_rises", 32'(rises - r0), 32'd32);

        // CLK_DIV=2 instance, loopback
        r0 = rises2; b0 = busy2_cyc; n = per_bad;
        tx_data2 = 32'h8000_0001;
        start2   = 1'b1;
        @(posedge GCLK); #1;
        start2 = 1'b0;
        d0 = 0;
        while (busy2 && d0 < 1000) begin @(posedge GCLK); #1; d0++; end
        check_eq("div2_idle", 32'(busy2), 32'd0);
        check_eq("div2_rx", rx_data2, 32'h8000_0001);
        check_eq("div2_rises", 32'(rises2 - r0), 32'd32);
        check_eq("div2_period", 32'(per_bad - n), 32'd0);
        check_eq("div2_busy_cycles", 32'(busy2_cyc - b0), 32'd137);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
